// File: rtl/scc_pkg.sv
// SCC wave engine shared constants, register-map offsets and mixer state type.
// Latency: n/a (declarations only).
// Backpressure: n/a; the engine has no flow control.
package scc_pkg;

  localparam int SCC_CHANNELS   = 5;
  localparam int SCC_WAVE_LEN   = 32;
  localparam int SCC_MIN_PERIOD = 9;

  // Register-map offsets inside the SCC window
  localparam logic [7:0] WAVE_END      = 8'h7F;
  localparam logic [7:0] FREQ_BASE     = 8'h80;
  localparam logic [7:0] VOL_BASE      = 8'h8A;
  localparam logic [7:0] MASK_ADDR     = 8'h8F;
  localparam logic [7:0] CH5_READ_BASE = 8'hA0;

  // Mixer walks one channel per clk between sound clock enables
  typedef enum logic [2:0] {
    MIX_IDLE,
    MIX_ACC0,
    MIX_ACC1,
    MIX_ACC2,
    MIX_ACC3,
    MIX_ACC4,
    MIX_OUT
  } scc_mix_state_t;

endpackage

// File: rtl/scc_channel_counter.sv
// One channel's period down-counter and 5-bit wave pointer.
// Latency: pointer/counter update on the clk where ce or load is high.
// Backpressure: none; a period load overrides a coincident ce tick.
module scc_channel_counter
  import scc_pkg::*;
#(
  parameter int MIN_PERIOD = SCC_MIN_PERIOD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic [11:0] period,
  output logic [4:0]  ptr
);

  logic [11:0] cnt;

  // Reload on period write, otherwise step the counter on each sound clock enable
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ptr <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (ce) begin
      if (period < 12'(MIN_PERIOD)) begin
        cnt <= cnt;
      end else if (cnt == 12'd0) begin
        cnt <= period;
        ptr <= ptr + 5'd1;
      end else begin
        cnt <= cnt - 12'd1;
      end
    end
  end

endmodule

// File: rtl/scc_wave_core.sv
// Konami SCC engine: 5 wavetable channels, register file, wave RAM and serial mixer.
// Latency: sound updates 7 clk after the clk carrying ce; dout is combinational from addr.
// Backpressure: none; ce arriving while the mixer is busy only ticks the channels.
module scc_wave_core
  import scc_pkg::*;
#(
  parameter int MIN_PERIOD = SCC_MIN_PERIOD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
  input  logic        wr,
  output logic [7:0]  dout,
  output logic [15:0] sound
);

  logic [7:0] wave_ram [0:4*SCC_WAVE_LEN-1];

  logic [SCC_CHANNELS-1:0][11:0] period_q;
  logic [SCC_CHANNELS-1:0][3:0]  vol_q;
  logic [SCC_CHANNELS-1:0]       mask_q;
  logic [SCC_CHANNELS-1:0]       load;
  logic [SCC_CHANNELS-1:0][11:0] load_val;
  logic [SCC_CHANNELS-1:0][4:0]  ptr;

  logic       reg_wr;
  logic [3:0] reg_idx;

  scc_mix_state_t     mix_state;
  logic signed [14:0] acc;
  logic [2:0]         mix_ch;
  logic               mix_active;
  logic [1:0]         mix_tbl;
  logic [7:0]         mix_sample;
  logic signed [12:0] mix_prod;
  logic signed [12:0] mix_term;

  // 0x80-0x9F is the control block, addr[4] is a don't-care mirror bit
  assign reg_wr  = wr && (addr[7:5] == FREQ_BASE[7:5]);
  assign reg_idx = addr[3:0];

  // Assemble the full 12-bit period a lo/hi write would produce for each channel
  always_comb begin
    for (int n = 0; n < SCC_CHANNELS; n++) begin
      load[n] = reg_wr && (reg_idx[3:1] == 3'(n));
      if (reg_idx[0]) begin
        load_val[n] = {din[3:0], period_q[n][7:0]};
      end else begin
        load_val[n] = {period_q[n][11:8], din};
      end
    end
  end

  // Control register file: periods, volumes and channel enable mask
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      vol_q    <= '0;
      mask_q   <= '0;
    end else begin
      for (int n = 0; n < SCC_CHANNELS; n++) begin
        if (load[n]) period_q[n] <= load_val[n];
      end
      if (reg_wr) begin
        case (reg_idx)
          VOL_BASE[3:0] + 4'd0: vol_q[0] <= din[3:0];
          VOL_BASE[3:0] + 4'd1: vol_q[1] <= din[3:0];
          VOL_BASE[3:0] + 4'd2: vol_q[2] <= din[3:0];
          VOL_BASE[3:0] + 4'd3: vol_q[3] <= din[3:0];
          VOL_BASE[3:0] + 4'd4: vol_q[4] <= din[3:0];
          MASK_ADDR[3:0]:       mask_q   <= din[4:0];
          default: ;
        endcase
      end
    end
  end

  // Wave RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr && (addr <= WAVE_END)) wave_ram[addr[6:0]] <= din;
  end

  // Read mux: wave RAM directly, 0xA0-0xBF aliases the shared ch3/ch4 table
  always_comb begin
    dout = 8'hFF;
    if (addr <= WAVE_END) begin
      dout = wave_ram[addr[6:0]];
    end else if (addr[7:5] == CH5_READ_BASE[7:5]) begin
      dout = wave_ram[{2'b11, addr[4:0]}];
    end
  end

  genvar g;
  generate
    for (g = 0; g < SCC_CHANNELS; g++) begin : g_ch
      scc_channel_counter #(.MIN_PERIOD(MIN_PERIOD)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .load     (load[g]),
        .load_val (load_val[g]),
        .period   (period_q[g]),
        .ptr      (ptr[g])
      );
    end
  endgenerate

  // Select the channel the mixer is visiting this clk
  always_comb begin
    mix_ch     = 3'd0;
    mix_active = 1'b1;
    case (mix_state)
      MIX_ACC0: mix_ch = 3'd0;
      MIX_ACC1: mix_ch = 3'd1;
      MIX_ACC2: mix_ch = 3'd2;
      MIX_ACC3: mix_ch = 3'd3;
      MIX_ACC4: mix_ch = 3'd4;
      default:  mix_active = 1'b0;
    endcase
  end

  // Single shared multiplier: signed sample times unsigned volume, gated by the mask
  always_comb begin
    mix_tbl    = (mix_ch == 3'd4) ? 2'd3 : mix_ch[1:0];
    mix_sample = wave_ram[{mix_tbl, ptr[mix_ch]}];
    mix_prod   = $signed(mix_sample) * $signed({1'b0, vol_q[mix_ch]});
    mix_term   = (mix_active && mask_q[mix_ch]) ? mix_prod : 13'sd0;
  end

  // Mixer FSM: clear on ce, accumulate five channels, then register the sum
  always_ff @(posedge clk) begin
    if (reset) begin
      mix_state <= MIX_IDLE;
      acc       <= '0;
      sound     <= '0;
    end else begin
      case (mix_state)
        MIX_IDLE: begin
          if (ce) begin
            acc       <= '0;
            mix_state <= MIX_ACC0;
          end
        end
        MIX_ACC0: begin
          acc       <= acc + 15'(mix_term);
          mix_state <= MIX_ACC1;
        end
        MIX_ACC1: begin
          acc       <= acc + 15'(mix_term);
          mix_state <= MIX_ACC2;
        end
        MIX_ACC2: begin
          acc       <= acc + 15'(mix_term);
          mix_state <= MIX_ACC3;
        end
        MIX_ACC3: begin
          acc       <= acc + 15'(mix_term);
          mix_state <= MIX_ACC4;
        end
        MIX_ACC4: begin
          acc       <= acc + 15'(mix_term);
          mix_state <= MIX_OUT;
        end
        MIX_OUT: begin
          sound     <= {acc[14], acc};
          mix_state <= MIX_IDLE;
        end
        default: mix_state <= MIX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scc_wave_core.sv
// Self-checking bench for scc_wave_core against a ce-count based channel model.
// Latency: checks sound 7 clk after each ce and dout combinationally.
// Backpressure: none; ce pulses are spaced 8 clk apart.
module tb_scc_wave_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [7:0]  addr;
  logic [7:0]  din;
  logic        wr;
  logic [7:0]  dout;
  logic [15:0] sound;

  int errors = 0;
  int checks = 0;

  // Reference state: a pointer is base + (ce ticks since last period load) / (period+1)
  logic [7:0] wave_m [0:127];
  int per_m  [5];
  int vol_m  [5];
  int base_m [5];
  int t_m    [5];
  int mask_m;

  always #5 clk = ~clk;

  scc_wave_core dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .addr  (addr),
    .din   (din),
    .wr    (wr),
    .dout  (dout),
    .sound (sound)
  );

  function automatic int ptr_m(int n);
    return (base_m[n] + t_m[n] / (per_m[n] + 1)) % 32;
  endfunction

  function automatic int mix_m();
    int s = 0;
    for (int n = 0; n < 5; n++) begin
      int tbl = (n == 4) ? 3 : n;
      if (mask_m[n]) s += int'($signed(wave_m[tbl*32 + ptr_m(n)])) * vol_m[n];
    end
    return s;
  endfunction

  function automatic logic [7:0] dout_m(int a);
    if (a < 128) return wave_m[a];
    if (a >= 160 && a < 192) return wave_m[96 + (a % 32)];
    return 8'hFF;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < 5; n++) begin
      per_m[n] = 0; vol_m[n] = 0; base_m[n] = 0; t_m[n] = 0;
    end
    mask_m = 0;
  endfunction

  // Returns the channel whose period was written, or -1
  function automatic int model_write(int a, int d);
    int idx, n;
    if (a < 128) begin
      wave_m[a] = 8'(d);
    end else if (a < 160) begin
      idx = a % 16;
      if (idx < 10) begin
        n = idx / 2;
        base_m[n] = ptr_m(n);
        t_m[n] = 0;
        if (idx % 2 == 1) per_m[n] = ((d % 16) * 256) + (per_m[n] % 256);
        else per_m[n] = (per_m[n] / 256) * 256 + d;
        return n;
      end else if (idx < 15) begin
        vol_m[idx - 10] = d % 16;
      end else begin
        mask_m = d % 32;
      end
    end
    return -1;
  endfunction

  function automatic void model_tick(int skip);
    for (int n = 0; n < 5; n++)
      if (n != skip && per_m[n] >= 9) t_m[n]++;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input int a, input int d);
    int unused;
    addr = 8'(a); din = 8'(d); wr = 1'b1;
    step();
    wr = 1'b0;
    unused = model_write(a, d);
  endtask

  task automatic pulse_ce();
    ce = 1'b1;
    step();
    ce = 1'b0;
    model_tick(-1);
    repeat (7) step();
  endtask

  task automatic ce_wr(input int a, input int d);
    int n;
    addr = 8'(a); din = 8'(d); wr = 1'b1; ce = 1'b1;
    step();
    wr = 1'b0; ce = 1'b0;
    n = model_write(a, d);
    model_tick(n);
    repeat (7) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    addr = 8'h80; #1;
    checks++;
    if (dout !== 8'hFF) begin errors++; $display("FAIL reset_rd80 got=%h exp=ff", dout); end
    addr = 8'hC0; #1;
    checks++;
    if (dout !== 8'hFF) begin errors++; $display("FAIL reset_rdC0 got=%h exp=ff", dout); end
    checks++;
    if (sound !== 16'd0) begin errors++; $display("FAIL reset_sound got=%0d exp=0", $signed(sound)); end
  endtask

  task automatic test_single();
    for (int i = 0; i < 32; i++) wr_reg(i, 8'h7F);
    wr_reg(8'h8A, 15);
    wr_reg(8'h8F, 8'h01);
    wr_reg(8'h80, 9);
    wr_reg(8'h81, 0);
    ce = 1'b1;
    step();
    ce = 1'b0;
    model_tick(-1);
    repeat (5) step();
    checks++;
    if (sound !== 16'd0) begin errors++; $display("FAIL single_early got=%0d exp=0", $signed(sound)); end
    step();
    checks++;
    if ($signed(sound) !== 16'sd1905) begin errors++; $display("FAIL single_lat7 got=%0d exp=1905", $signed(sound)); end
    checks++;
    if (sound !== 16'(mix_m())) begin errors++; $display("FAIL single_model got=%0d exp=%0d", $signed(sound), mix_m()); end
    step();
  endtask

  task automatic test_ramp();
    do_reset();
    for (int i = 0; i < 32; i++) wr_reg(i, i);
    wr_reg(8'h8A, 1);
    wr_reg(8'h8F, 8'h01);
    wr_reg(8'h80, 9);
    wr_reg(8'h81, 0);
    for (int k = 1; k <= 320; k++) begin
      pulse_ce();
      checks++;
      if (sound !== 16'(mix_m())) begin errors++; $display("FAIL ramp_ce%0d got=%0d exp=%0d", k, $signed(sound), mix_m()); end
      if (k == 9 || k == 10 || k == 320) begin
        checks++;
        if ($signed(sound) !== ((k == 10) ? 1 : 0)) begin
          errors++; $display("FAIL ramp_step_ce%0d got=%0d exp=%0d", k, $signed(sound), (k == 10) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_freeze();
    repeat (25) pulse_ce();
    checks++;
    if ($signed(sound) !== 2) begin errors++; $display("FAIL freeze_pre got=%0d exp=2", $signed(sound)); end
    wr_reg(8'h80, 8);
    for (int k = 0; k < 1000; k++) begin
      pulse_ce();
      checks++;
      if (sound !== 16'(mix_m())) begin errors++; $display("FAIL freeze_ce%0d got=%0d exp=%0d", k, $signed(sound), mix_m()); end
    end
    checks++;
    if ($signed(sound) !== 2) begin errors++; $display("FAIL freeze_held got=%0d exp=2", $signed(sound)); end
    wr_reg(8'h80, 9);
    repeat (9) pulse_ce();
    checks++;
    if ($signed(sound) !== 2) begin errors++; $display("FAIL resume_ce9 got=%0d exp=2", $signed(sound)); end
    pulse_ce();
    checks++;
    if ($signed(sound) !== 3) begin errors++; $display("FAIL resume_ce10 got=%0d exp=3", $signed(sound)); end
  endtask

  task automatic test_all_neg();
    for (int i = 0; i < 128; i++) wr_reg(i, 8'h80);
    for (int n = 0; n < 5; n++) wr_reg(8'h8A + n, 15);
    wr_reg(8'h8F, 8'h1F);
    pulse_ce();
    checks++;
    if ($signed(sound) !== -16'sd9600) begin errors++; $display("FAIL allneg_5ch got=%0d exp=-9600", $signed(sound)); end
    wr_reg(8'h9F, 8'h0F);
    pulse_ce();
    checks++;
    if ($signed(sound) !== -16'sd7680) begin errors++; $display("FAIL allneg_4ch got=%0d exp=-7680", $signed(sound)); end
  endtask

  task automatic test_mirror_reset();
    wr_reg(8'h65, 8'h12);
    wr_reg(8'hA5, 8'h34);
    addr = 8'hA5; #1;
    checks++;
    if (dout !== 8'h12) begin errors++; $display("FAIL mirror_rdA5 got=%h exp=12", dout); end
    addr = 8'h65; #1;
    checks++;
    if (dout !== 8'h12) begin errors++; $display("FAIL mirror_rd65 got=%h exp=12", dout); end
    checks++;
    if ($signed(sound) !== -16'sd7680) begin errors++; $display("FAIL prereset_sound got=%0d exp=-7680", $signed(sound)); end
    ce = 1'b1;
    step();
    ce = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    checks++;
    if (sound !== 16'd0) begin errors++; $display("FAIL midacc_reset got=%0d exp=0", $signed(sound)); end
    repeat (8) step();
    checks++;
    if (sound !== 16'd0) begin errors++; $display("FAIL midacc_stays0 got=%0d exp=0", $signed(sound)); end
  endtask

  task automatic test_random();
    int a, d, op;
    for (int i = 0; i < 128; i++) wr_reg(i, $urandom_range(0, 255));
    for (int n = 0; n < 5; n++) begin
      wr_reg(8'h8A + n, $urandom_range(0, 15));
      wr_reg(8'h80 + 2*n, $urandom_range(0, 20));
    end
    wr_reg(8'h8F, $urandom_range(0, 31));
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      a  = $urandom_range(0, 255);
      d  = $urandom_range(0, 255);
      if (a >= 128 && a < 160 && (a % 16) < 10) begin
        if (a % 2 == 0) d = $urandom_range(0, 24);
        else d = d & 8'hF0;
      end
      if (op < 4) begin
        wr_reg(a, d);
      end else if (op == 4) begin
        a = (($urandom_range(0, 1) == 1) ? 8'h90 : 8'h80) + 2 * $urandom_range(0, 4);
        ce_wr(a, $urandom_range(0, 24));
        checks++;
        if (sound !== 16'(mix_m())) begin errors++; $display("FAIL rand_cewr%0d got=%0d exp=%0d", it, $signed(sound), mix_m()); end
      end else begin
        pulse_ce();
        checks++;
        if (sound !== 16'(mix_m())) begin errors++; $display("FAIL rand_ce%0d got=%0d exp=%0d", it, $signed(sound), mix_m()); end
      end
      addr = 8'($urandom_range(0, 255)); #1;
      checks++;
      if (dout !== dout_m(int'(addr))) begin errors++; $display("FAIL rand_rd%0d addr=%h got=%h exp=%h", it, addr, dout, dout_m(int'(addr))); end
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; wr = 1'b0; addr = 8'h00; din = 8'h00;
    for (int i = 0; i < 128; i++) wave_m[i] = 8'h00;
    model_reset();
    step();
    test_reset();
    test_single();
    test_ramp();
    test_freeze();
    test_all_neg();
    test_mirror_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
